// File: rtl/rx_frame_pkg.sv
// Shared definitions for the PSK receive frame controller: FSM state encoding,
// default flush length and a counter-width helper.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FLUSH   = 2'd3
    } rx_state_e;

    localparam int FLUSH_CYCLES_DEFAULT = 4;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_dn_cnt.sv
// Loadable saturating down-counter with a "count == 1" terminal flag, used for
// the boundary-search timeout and the post-frame flush length.
module rx_dn_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             one_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Saturates at zero, so a zero load never produces a terminal flag.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: waits for a preamble, searches for the bit boundary,
// gates a fixed-length polarity-corrected payload, then holds the BD in clear.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int LEN_WIDTH        = 12,
    parameter int TIMEOUT_WIDTH    = 16,
    parameter int FLUSH_CYCLES     = FLUSH_CYCLES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] cfg_bd_window,
    input  logic [LEN_WIDTH-1:0]        cfg_payload_bits,
    input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
    input  logic                        PD_flag,
    input  logic                        BD_flag,
    input  logic                        BD_sgn,
    input  logic                        sym_vld,
    input  logic                        bit_in,
    output logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    output logic                        disassert_BD,
    output logic                        bit_out,
    output logic                        bit_vld,
    output logic                        frame_start,
    output logic                        frame_end,
    output logic                        frame_err,
    output logic                        busy,
    output logic [1:0]                  state
);

    localparam int FLUSH_W = cnt_width(FLUSH_CYCLES);

    rx_state_e state_q, state_d;

    logic                        pd_q;
    logic                        pol_q, pol_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        bit_cnt_q, bit_cnt_d;
    logic [MAX_WINDOW_WIDTH-1:0] window_q, window_d;
    logic                        disassert_q, disassert_d;
    logic                        bit_out_q, bit_out_d;
    logic                        bit_vld_q, bit_vld_d;
    logic                        frame_start_q, frame_start_d;
    logic                        frame_end_q, frame_end_d;
    logic                        frame_err_q, frame_err_d;
    logic                        busy_q, busy_d;

    logic pd_rise;
    logic last_bit;
    logic tmo_load, tmo_one;
    logic flush_load, flush_one;

    assign pd_rise  = PD_flag && !pd_q;
    assign last_bit = sym_vld && (bit_cnt_q == (len_q - LEN_WIDTH'(1)));

    assign tmo_load   = (state_q == ST_IDLE) && pd_rise;
    assign flush_load = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

    rx_dn_cnt #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmo_load),
        .load_val_i (cfg_timeout),
        .dec_i      (state_q == ST_SEARCH),
        .one_o      (tmo_one)
    );

    rx_dn_cnt #(
        .WIDTH (FLUSH_W)
    ) u_flush_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (flush_load),
        .load_val_i (FLUSH_W'(FLUSH_CYCLES)),
        .dec_i      (state_q == ST_FLUSH),
        .one_o      (flush_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pd_q          <= 1'b0;
            pol_q         <= 1'b0;
            len_q         <= '0;
            bit_cnt_q     <= '0;
            window_q      <= '0;
            disassert_q   <= 1'b0;
            bit_out_q     <= 1'b0;
            bit_vld_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pd_q          <= PD_flag;
            pol_q         <= pol_d;
            len_q         <= len_d;
            bit_cnt_q     <= bit_cnt_d;
            window_q      <= window_d;
            disassert_q   <= disassert_d;
            bit_out_q     <= bit_out_d;
            bit_vld_q     <= bit_vld_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pd_rise) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (BD_flag) begin
                    state_d = (len_q == '0) ? ST_FLUSH : ST_PAYLOAD;
                end else if (!PD_flag || tmo_one) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_PAYLOAD: begin
                if (last_bit || !PD_flag) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_one) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pol_d         = pol_q;
        len_d         = len_q;
        bit_cnt_d     = bit_cnt_q;
        window_d      = window_q;
        bit_out_d     = bit_out_q;
        bit_vld_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_err_d   = 1'b0;
        disassert_d   = (state_d == ST_FLUSH);
        busy_d        = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (pd_rise) begin
                    window_d = cfg_bd_window;
                    len_d    = cfg_payload_bits;
                end
            end
            ST_SEARCH: begin
                if (BD_flag) begin
                    pol_d         = BD_sgn;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = '0;
                    frame_end_d   = (len_q == '0);
                end else if (!PD_flag || tmo_one) begin
                    frame_err_d = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (sym_vld) begin
                    bit_out_d = bit_in ^ pol_q;
                    bit_vld_d = 1'b1;
                end
                // The final bit wins over a simultaneous preamble loss.
                if (last_bit) begin
                    frame_end_d = 1'b1;
                end else begin
                    if (sym_vld) begin
                        bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
                    end
                    if (!PD_flag) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign RX_BD_WINDOW = window_q;
    assign disassert_BD = disassert_q;
    assign bit_out      = bit_out_q;
    assign bit_vld      = bit_vld_q;
    assign frame_start  = frame_start_q;
    assign frame_end    = frame_end_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: nominal/inverted frames, timeout, preamble
// loss, zero-length, disabled timeout, BD/timeout collision and async reset.
module tb_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_bd_window;
    logic [11:0] cfg_payload_bits;
    logic [15:0] cfg_timeout;
    logic        PD_flag, BD_flag, BD_sgn, sym_vld, bit_in;
    logic [7:0]  RX_BD_WINDOW;
    logic        disassert_BD, bit_out, bit_vld;
    logic        frame_start, frame_end, frame_err, busy;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    rx_frame_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_bd_window    (cfg_bd_window),
        .cfg_payload_bits (cfg_payload_bits),
        .cfg_timeout      (cfg_timeout),
        .PD_flag          (PD_flag),
        .BD_flag          (BD_flag),
        .BD_sgn           (BD_sgn),
        .sym_vld          (sym_vld),
        .bit_in           (bit_in),
        .RX_BD_WINDOW     (RX_BD_WINDOW),
        .disassert_BD     (disassert_BD),
        .bit_out          (bit_out),
        .bit_vld          (bit_vld),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .frame_err        (frame_err),
        .busy             (busy),
        .state            (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the terminating-event edge: four clear cycles, then idle.
    task automatic flush_check(input string tag);
        chk({tag, "_dis_first"}, {31'd0, disassert_BD}, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_dis_hold"}, {30'd0, disassert_BD, busy}, 2'b11);
        end
        tick();
        chk({tag, "_dis_low"}, {31'd0, disassert_BD}, 0);
        chk({tag, "_idle"}, {30'd0, state}, 0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 0);
    endtask

    task automatic start_search(input logic [7:0] win, input logic [11:0] len,
                                input logic [15:0] tmo, input string tag);
        PD_flag = 1'b0;
        tick();
        cfg_bd_window    = win;
        cfg_payload_bits = len;
        cfg_timeout      = tmo;
        PD_flag          = 1'b1;
        tick();
        chk({tag, "_search"}, {30'd0, state}, 1);
        chk({tag, "_window"}, {24'd0, RX_BD_WINDOW}, {24'd0, win});
        cfg_bd_window    = 8'hFF;
        cfg_payload_bits = 12'd3;
        cfg_timeout      = 16'd2;
    endtask

    task automatic bd_hit(input logic sgn, input string tag);
        BD_flag = 1'b1;
        BD_sgn  = sgn;
        tick();
        BD_flag = 1'b0;
        BD_sgn  = 1'b0;
        chk({tag, "_fstart"}, {31'd0, frame_start}, 1);
    endtask

    task automatic send_bit(input logic b, input logic exp_out, input logic exp_end,
                            input logic exp_err, input string tag);
        sym_vld = 1'b1;
        bit_in  = b;
        tick();
        sym_vld = 1'b0;
        bit_in  = 1'b0;
        chk({tag, "_bit"}, {28'd0, bit_vld, bit_out, frame_end, frame_err},
            {28'd0, 1'b1, exp_out, exp_end, exp_err});
    endtask

    task automatic full_frame(input logic sgn, input string tag);
        logic [7:0] d;
        int         errs;
        d    = 8'hA5;
        errs = 0;
        start_search(8'd4, 12'd8, 16'd100, tag);
        for (int i = 0; i < 9; i++) begin
            tick();
            errs += int'(frame_err) + int'(frame_start);
        end
        chk({tag, "_no_early_evt"}, errs, 0);
        bd_hit(sgn, tag);
        chk({tag, "_payload"}, {30'd0, state}, 2);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[7-i], d[7-i] ^ sgn, (i == 7), 1'b0, tag);
            if (i != 7) begin
                tick();
                chk({tag, "_gap"}, {31'd0, bit_vld}, 0);
            end
        end
        chk({tag, "_window_kept"}, {24'd0, RX_BD_WINDOW}, 4);
        flush_check(tag);
    endtask

    initial begin
        int errs;
        int first_err;

        rst = 1'b1;
        cfg_bd_window = '0; cfg_payload_bits = '0; cfg_timeout = '0;
        PD_flag = 0; BD_flag = 0; BD_sgn = 0; sym_vld = 0; bit_in = 0;
        #1;
        chk("reset_outputs", {RX_BD_WINDOW, disassert_BD, bit_out, bit_vld, frame_start,
                              frame_end, frame_err, busy, state}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {30'd0, state}, 0);

        full_frame(1'b0, "nominal");
        full_frame(1'b1, "inverted");

        // Timeout: PD rise sampled on edge 1, error visible after edge 21.
        PD_flag = 1'b0;
        tick();
        cfg_bd_window = 8'd4; cfg_payload_bits = 12'd8; cfg_timeout = 16'd20;
        PD_flag = 1'b1;
        first_err = 0;
        errs = 0;
        for (int n = 1; n <= 21; n++) begin
            tick();
            if (frame_err && first_err == 0) first_err = n;
            errs += int'(frame_start);
        end
        chk("timeout_cycle", first_err, 21);
        chk("timeout_no_start", errs, 0);
        flush_check("timeout");
        errs = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            errs += int'(state != 2'd0);
        end
        chk("no_retrigger", errs, 0);
        start_search(8'd7, 12'd8, 16'd20, "retrigger");
        PD_flag = 1'b0;
        tick();
        chk("search_pd_loss", {30'd0, frame_err, frame_start}, 2'b10);
        flush_check("search_loss");

        // Preamble loss after three payload bits.
        start_search(8'd4, 12'd8, 16'd100, "loss3");
        bd_hit(1'b0, "loss3");
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, "loss3");
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, "loss3");
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, "loss3");
        PD_flag = 1'b0;
        tick();
        chk("loss3_evt", {29'd0, frame_err, frame_end, bit_vld}, 3'b100);
        flush_check("loss3");

        // Preamble loss coincident with the final bit.
        start_search(8'd4, 12'd8, 16'd100, "loss8");
        bd_hit(1'b0, "loss8");
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0, "loss8");
        PD_flag = 1'b0;
        send_bit(1'b1, 1'b1, 1'b1, 1'b0, "loss8_last");
        flush_check("loss8");

        // Zero-length payload.
        start_search(8'd9, 12'd0, 16'd100, "len0");
        bd_hit(1'b0, "len0");
        chk("len0_evt", {29'd0, frame_end, bit_vld, frame_err}, 3'b100);
        chk("len0_flush", {30'd0, state}, 3);
        flush_check("len0");

        // Timeout disabled, boundary only after 5000 cycles.
        start_search(8'd4, 12'd8, 16'd0, "tmo0");
        errs = 0;
        for (int n = 0; n < 5000; n++) begin
            tick();
            errs += int'(frame_err) + int'(state != 2'd1);
        end
        chk("tmo0_no_err", errs, 0);
        bd_hit(1'b0, "tmo0");
        PD_flag = 1'b0;
        tick();
        chk("tmo0_payload_loss", {31'd0, frame_err}, 1);
        flush_check("tmo0");

        // Boundary arrives on the very edge the timeout would fire.
        start_search(8'd4, 12'd8, 16'd20, "collide");
        for (int n = 2; n <= 20; n++) tick();
        chk("collide_pre", {30'd0, frame_err, frame_start}, 0);
        bd_hit(1'b1, "collide");
        chk("collide_no_err", {31'd0, frame_err}, 0);
        PD_flag = 1'b0;
        tick();
        flush_check("collide");

        // Asynchronous reset in the middle of a payload.
        start_search(8'd4, 12'd8, 16'd100, "rst");
        bd_hit(1'b0, "rst");
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, "rst");
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, "rst");
        send_bit(1'b0, 1'b0, 1'b0, 1'b0, "rst");
        rst = 1'b1;
        PD_flag = 1'b0;
        #1;
        chk("rst_async_outputs", {RX_BD_WINDOW, disassert_BD, bit_out, bit_vld, frame_start,
                                  frame_end, frame_err, busy, state}, 0);
        tick();
        rst = 1'b0;
        errs = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            errs += int'(frame_start) + int'(frame_end) + int'(frame_err) +
                    int'(bit_vld) + int'(state != 2'd0);
        end
        chk("rst_quiet", errs, 0);
        start_search(8'd6, 12'd8, 16'd100, "post_rst");
        PD_flag = 1'b0;
        tick();
        flush_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive frame controller for the PSK receiver: sequences the bit-boundary detector (BD) after preamble detection, owns the BD window configuration and its release (`disassert_BD`), then gates demodulated bits into a fixed-length payload with polarity correction from `BD_sgn`. It sits between preamble detection and the byte/packet layer and reports frame start, end and error events.

## Interface
- `MAX_WINDOW_WIDTH`, 8, width of the BD window config, matching the BD block.
- `LEN_WIDTH`, 12, width of the payload length in bits.
- `TIMEOUT_WIDTH`, 16, width of the BD-search timeout in clock cycles.
- `FLUSH_CYCLES`, 4, cycles `disassert_BD` is held after every frame.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `cfg_bd_window` in MAX_WINDOW_WIDTH: BD window, latched on frame start.
- `cfg_payload_bits` in LEN_WIDTH: payload length in bits, latched on frame start.
- `cfg_timeout` in TIMEOUT_WIDTH: SEARCH timeout; 0 disables it.
- `PD_flag` in 1: preamble-detected level.
- `BD_flag` in 1: boundary confirmed (level, from BD).
- `BD_sgn` in 1: boundary sign; 1 = inverted polarity.
- `sym_vld` in 1: one-cycle strobe per decided bit.
- `bit_in` in 1: decided bit, qualified by `sym_vld`.
- `RX_BD_WINDOW` out MAX_WINDOW_WIDTH: window driven to BD.
- `disassert_BD` out 1: BD clear/hold.
- `bit_out` out 1: polarity-corrected payload bit.
- `bit_vld` out 1: strobe for `bit_out`.
- `frame_start`, `frame_end`, `frame_err` out 1 each: one-cycle event pulses.
- `busy` out 1: state ≠ IDLE.
- `state` out 2: current FSM state.

## Operation
- FSM states: IDLE(0), SEARCH(1), PAYLOAD(2), FLUSH(3).
- IDLE: `disassert_BD`=0. On a `PD_flag` rising edge (registered `pd_d` = 0, `PD_flag` = 1): latch all cfg inputs, load the timeout counter with `cfg_timeout`, go to SEARCH. A `PD_flag` held high from a previous frame does not retrigger.
- SEARCH:
  - `BD_flag`=1: latch `BD_sgn` as `pol`, pulse `frame_start`, clear the bit counter, go to PAYLOAD. If the latched length is 0, also pulse `frame_end` and go to FLUSH.
  - Else `PD_flag`=0: pulse `frame_err`, go to FLUSH.
  - Else timeout enabled and counter == 1: pulse `frame_err`, go to FLUSH. The counter decrements every cycle in SEARCH.
  - `sym_vld` is ignored in SEARCH.
- PAYLOAD:
  - On `sym_vld`: `bit_out` = `bit_in` ^ `pol`, pulse `bit_vld`, increment the bit counter.
  - When the counter reaches latched length − 1 on a `sym_vld`: the last bit is emitted, `frame_end` pulses, go to FLUSH.
  - `PD_flag`=0 without a final bit that cycle: `frame_err`, go to FLUSH.
- FLUSH: `disassert_BD`=1 for exactly FLUSH_CYCLES cycles, then IDLE.
- `RX_BD_WINDOW` holds the latched window from SEARCH entry until the next latch.
- Priority in the same cycle:
  - SEARCH: `BD_flag` > `PD_flag` loss > timeout.
  - PAYLOAD: final `sym_vld` > `PD_flag` loss, so that frame ends cleanly with no `frame_err`.
  - `frame_end` and `frame_err` never pulse in the same cycle.
- Bit counter is LEN_WIDTH wide and never wraps; it stops at the terminal count.

## Timing
- Reset values:
  - state = IDLE; `pd_d`, `pol` = 0.
  - All outputs 0: `RX_BD_WINDOW`=0, `disassert_BD`=0, `bit_out`=0, `bit_vld`=0, all pulses 0, `busy`=0.
  - Counters cleared.
- Reset mid-frame: immediate return to IDLE, no event pulse.
- All outputs are registered:
  - `frame_start` is high the cycle after the `BD_flag`=1 sample.
  - `bit_vld`/`bit_out` are high the cycle after the `sym_vld` sample.
  - `frame_end` is coincident with the last `bit_vld`.
- `disassert_BD` rises the cycle after the terminating event and stays high FLUSH_CYCLES cycles. `busy` drops the cycle after.
- Timeout T (T>0): `frame_err` is issued T+1 cycles after SEARCH entry if there is no `BD_flag`.

## Structure
- Package `rx_frame_pkg`: state encoding constants (IDLE/SEARCH/PAYLOAD/FLUSH = 0..3) and the default FLUSH_CYCLES.
- One sub-module `rx_dn_cnt`: loadable down-counter with a terminal flag. It is instantiated twice, once for the SEARCH timeout and once for the FLUSH length. The rest is a single FSM always-block.

## Test plan
- Nominal frame:
  - Setup: window=4, length=8, timeout=100, `PD_flag` rise, `BD_flag` at cycle 10 with `BD_sgn`=0, 8 `sym_vld` strobes carrying 0xA5 MSB-first.
  - Expected: `frame_start` once, 8 `bit_vld` with `bit_out` = 1,0,1,0,0,1,0,1, `frame_end` on the 8th, `disassert_BD` high 4 cycles, then IDLE. `RX_BD_WINDOW`=4 throughout.
- Inverted polarity: same frame with `BD_sgn`=1 → `bit_out` = 0,1,0,1,1,0,1,0.
- Timeout: timeout=20, no `BD_flag` → `frame_err` 21 cycles after SEARCH entry, FLUSH 4 cycles. No retrigger while `PD_flag` stays high; a new rising edge restarts.
- Preamble loss: `PD_flag` drops after 3 payload bits → `frame_err`, no `frame_end`. Loss coincident with the 8th `sym_vld` → `frame_end` only.
- Boundary cases:
  - length=0 → `frame_start` and `frame_end` in the same cycle, no `bit_vld`.
  - timeout=0 with `BD_flag` at cycle 5000 → no error.
  - `BD_flag` and timeout in the same cycle → `frame_start`.
- Reset: async `rst` asserted mid-PAYLOAD → all outputs 0 and state IDLE without waiting for a clock edge. No pulses after release until a new `PD_flag` rising edge.
